// File: rtl/alu_share_pkg.sv
// Shared types and constants for the round-robin ALU sharing controller.
package alu_share_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE,
      RESP
   } state_t;

   localparam logic [2:0] ADD = 3'd0;
   localparam logic [2:0] SUB = 3'd1;
   localparam logic [2:0] NOT = 3'd2;
   localparam logic [2:0] AND = 3'd3;
   localparam logic [2:0] OR  = 3'd4;
   localparam logic [2:0] XOR = 3'd5;
   localparam logic [2:0] LT  = 3'd6;
   localparam logic [2:0] EQ  = 3'd7;

   // Compare-and-subtract wrap so non-power-of-two requester counts stay in range.
   function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? (idx + 1 - n) : (idx + 1);
   endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_pick.sv
// Combinational round-robin pick: first valid index at or after rr_ptr, wrapping modulo NREQ.
module rr_pick
   import alu_share_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = 2
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [IW-1:0]   rr_ptr,
   output logic [NREQ-1:0] gnt_onehot,
   output logic [IW-1:0]   gnt_idx,
   output logic            any_valid
);

   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      found      = 1'b0;
      idx        = rr_ptr;
      for (int k = 0; k < int'(NREQ); k++) begin
         if (!found && req_valid[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
         idx = IW'(wrap_next(int'(idx), NREQ));
      end
      gnt_onehot[gnt_idx] = found;
      any_valid           = |req_valid;
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one registered ALU among NREQ requesters.
// Optional per-requester grant counters are enabled with `define ALU_SHARE_STATS_EN.
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned ALU_LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*3-1:0]     req_mode,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       resp_valid,
   input  logic [NREQ-1:0]       resp_ready,
   output logic [WIDTH-1:0]      resp_y,
   output logic                  resp_zero,
   output logic                  resp_ovf,
   output logic                  resp_d,
   output logic [2:0]            alu_mode,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   input  logic [WIDTH-1:0]      alu_y,
   input  logic                  alu_zero,
   input  logic                  alu_ovf,
   input  logic                  alu_d,
   output logic                  busy
`ifdef ALU_SHARE_STATS_EN
   ,
   output logic [NREQ*8-1:0]     grant_cnt
`endif
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = $clog2(ALU_LAT + 1);

   state_t        state_q;
   logic [IW-1:0] rr_ptr_q;
   logic [IW-1:0] gnt_q;
   logic [CW-1:0] wait_cnt_q;

   logic [NREQ-1:0] gnt_onehot;
   logic [IW-1:0]   gnt_idx;
   logic            any_valid;
   logic            accept;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .req_valid  (req_valid),
      .rr_ptr     (rr_ptr_q),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any_valid  (any_valid)
   );

   // Grant is offered only while idle; the handshake completes in the same cycle.
   assign accept    = (state_q == IDLE) && any_valid;
   assign req_ready = (state_q == IDLE && !rst) ? gnt_onehot : '0;
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         gnt_q      <= '0;
         wait_cnt_q <= '0;
         alu_mode   <= 3'b000;
         alu_a      <= '0;
         alu_b      <= '0;
         resp_valid <= '0;
         resp_y     <= '0;
         resp_zero  <= 1'b0;
         resp_ovf   <= 1'b0;
         resp_d     <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  alu_mode   <= req_mode[int'(gnt_idx)*3 +: 3];
                  alu_a      <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                  alu_b      <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                  gnt_q      <= gnt_idx;
                  wait_cnt_q <= CW'(1);
                  state_q    <= ISSUE;
               end
            end
            ISSUE, WAIT: begin
               if (wait_cnt_q == CW'(ALU_LAT)) begin
                  state_q <= CAPTURE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CW'(1);
                  state_q    <= WAIT;
               end
            end
            CAPTURE: begin
               resp_y     <= alu_y;
               resp_zero  <= alu_zero;
               resp_ovf   <= alu_ovf;
               resp_d     <= alu_d;
               resp_valid <= NREQ'(1) << gnt_q;
               wait_cnt_q <= '0;
               state_q    <= RESP;
            end
            RESP: begin
               // A stalled response deliberately blocks the shared ALU.
               if (resp_ready[gnt_q]) begin
                  resp_valid <= '0;
                  rr_ptr_q   <= IW'(wrap_next(int'(gnt_q), NREQ));
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   a_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(req_ready) && $onehot0(resp_valid));

`ifdef ALU_SHARE_STATS_EN
   logic [7:0] cnt_q [NREQ];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREQ); i++) cnt_q[i] <= '0;
      end else if (accept && cnt_q[gnt_idx] != 8'hFF) begin
         cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 8'd1;
      end
   end

   for (genvar i = 0; i < int'(NREQ); i++) begin : g_cnt
      assign grant_cnt[8*i +: 8] = cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed scoreboard bench for alu_share_ctrl with a registered 4-bit ALU model.
module tb_alu_share_ctrl;
   import alu_share_pkg::*;

   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 4;

   typedef struct packed {
      logic [W-1:0] y;
      logic         z;
      logic         v;
      logic         d;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*3-1:0] req_mode;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   resp_valid;
   logic [NREQ-1:0]   resp_ready;
   logic [W-1:0]      resp_y;
   logic              resp_zero;
   logic              resp_ovf;
   logic              resp_d;
   logic [2:0]        alu_mode;
   logic [W-1:0]      alu_a;
   logic [W-1:0]      alu_b;
   logic [W-1:0]      alu_y;
   logic              alu_zero;
   logic              alu_ovf;
   logic              alu_d;
   logic              busy;
`ifdef ALU_SHARE_STATS_EN
   logic [NREQ*8-1:0] grant_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   exp_t sb [NREQ][$];

   alu_share_ctrl #(
      .NREQ    (NREQ),
      .WIDTH   (W),
      .ALU_LAT (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_mode   (req_mode),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_y     (resp_y),
      .resp_zero  (resp_zero),
      .resp_ovf   (resp_ovf),
      .resp_d     (resp_d),
      .alu_mode   (alu_mode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_y      (alu_y),
      .alu_zero   (alu_zero),
      .alu_ovf    (alu_ovf),
      .alu_d      (alu_d),
      .busy       (busy)
`ifdef ALU_SHARE_STATS_EN
      ,
      .grant_cnt  (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU model: Y registered once, flags one cycle later from the registered Y.
   logic [W-1:0] nxt_y;
   logic         nxt_v, nxt_d, v1, d1;

   always_comb begin
      nxt_y = '0;
      nxt_v = 1'b0;
      nxt_d = 1'b0;
      case (alu_mode)
         ADD: begin
            nxt_y = alu_a + alu_b;
            nxt_v = (alu_a[3] == alu_b[3]) && (nxt_y[3] != alu_a[3]);
         end
         SUB: begin
            nxt_y = alu_a - alu_b;
            nxt_v = (alu_a[3] != alu_b[3]) && (nxt_y[3] != alu_a[3]);
         end
         NOT: nxt_y = ~alu_a;
         AND: nxt_y = alu_a & alu_b;
         OR:  nxt_y = alu_a | alu_b;
         XOR: nxt_y = alu_a ^ alu_b;
         LT: begin
            nxt_y = alu_a - alu_b;
            nxt_d = $signed(alu_a) < $signed(alu_b);
         end
         default: begin
            nxt_y = alu_a - alu_b;
            nxt_d = (alu_a == alu_b);
         end
      endcase
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_y <= '0; v1 <= 1'b0; d1 <= 1'b0;
         alu_zero <= 1'b0; alu_ovf <= 1'b0; alu_d <= 1'b0;
      end else begin
         alu_y    <= nxt_y;
         v1       <= nxt_v;
         d1       <= nxt_d;
         alu_zero <= (alu_y == '0);
         alu_ovf  <= v1;
         alu_d    <= d1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Response monitor: pops the per-requester scoreboard on each response handshake.
   always @(negedge clk) begin
      if (!rst) begin
         check("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
         check("resp_valid_onehot0", 32'($onehot0(resp_valid)), 32'd1);
         for (int i = 0; i < int'(NREQ); i++) begin
            if (resp_valid[i] && resp_ready[i]) begin
               check("resp_expected", 32'(sb[i].size() != 0), 32'd1);
               if (sb[i].size() != 0) begin
                  exp_t e;
                  e = sb[i].pop_front();
                  check("resp_y", 32'(resp_y), 32'(e.y));
                  check("resp_flags", 32'({resp_zero, resp_ovf, resp_d}), 32'({e.z, e.v, e.d}));
               end
            end
         end
      end
   end

   function automatic bit sb_empty();
      for (int i = 0; i < int'(NREQ); i++) if (sb[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic put_req(input int idx, input logic [2:0] m, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      req_valid[idx]       = 1'b1;
      req_mode[idx*3 +: 3] = m;
      req_a[idx*W +: W]    = a;
      req_b[idx*W +: W]    = b;
   endtask

   task automatic set_req(input int idx, input logic [2:0] m, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      @(posedge clk);
      #1;
      put_req(idx, m, a, b);
   endtask

   task automatic wait_any_grant(output int g);
      int n;
      g = -1;
      n = 0;
      while (g < 0 && n < 30) begin
         @(negedge clk);
         for (int i = 0; i < int'(NREQ); i++) if (req_ready[i]) g = i;
         n++;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (n < 60 && !sb_empty()) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(sb_empty()), 32'd1);
   endtask

   task automatic do_op(input int idx, input logic [2:0] m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e);
      int g;
      sb[idx].push_back(e);
      set_req(idx, m, a, b);
      wait_any_grant(g);
      check("op_grant", 32'(g), 32'(idx));
      @(posedge clk);
      #1;
      req_valid[idx] = 1'b0;
      wait_drain();
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int g;
      int rr_order[5];
      int bp_order[3];
      rr_order = '{0, 1, 2, 3, 0};
      bp_order = '{3, 0, 1};

      rst        = 1'b1;
      req_valid  = '0;
      req_mode   = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_handshake", 32'({req_ready, resp_valid}), 32'd0);
      check("reset_alu", 32'({alu_mode, alu_a, alu_b}), 32'd0);
      check("reset_resp", 32'({resp_y, resp_zero, resp_ovf, resp_d}), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Reset during WAIT: response is lost, nothing is pushed.
      set_req(0, ADD, 4'd1, 4'd2);
      @(negedge clk);
      check("rstw_ready", 32'(req_ready), 32'b0001);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk);
      check("rstw_busy_issue", 32'(busy), 32'd1);
      check("rstw_alu_held", 32'({alu_a, alu_b}), 32'h12);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rstw_busy", 32'(busy), 32'd0);
      check("rstw_resp_valid", 32'(resp_valid), 32'd0);
      check("rstw_alu_ab", 32'({alu_a, alu_b}), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single request with latency check: ready at cycle 0, response at cycle 4.
      sb[1].push_back('{y: 4'd7, z: 1'b0, v: 1'b0, d: 1'b0});
      set_req(1, ADD, 4'd3, 4'd4);
      @(negedge clk);
      check("single_ready_c0", 32'(req_ready), 32'b0010);
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check("single_no_resp_early", 32'(resp_valid), 32'd0);
         check("single_alu_a_held", 32'(alu_a), 32'd3);
      end
      @(negedge clk);
      check("single_resp_c4", 32'(resp_valid), 32'b0010);
      wait_drain();

      do_op(0, ADD, 4'h7, 4'h1, '{y: 4'h8, z: 1'b0, v: 1'b1, d: 1'b0});
      do_op(0, SUB, 4'h5, 4'h5, '{y: 4'h0, z: 1'b1, v: 1'b0, d: 1'b0});
      do_op(2, LT,  4'hE, 4'h2, '{y: 4'hC, z: 1'b0, v: 1'b0, d: 1'b1});
      do_op(3, EQ,  4'h9, 4'h9, '{y: 4'h0, z: 1'b1, v: 1'b0, d: 1'b1});

      // Round robin with all requesters held valid.
      reset_pulse();
      resp_ready = '1;
      for (int i = 0; i < int'(NREQ); i++) begin
         sb[i].push_back('{y: 4'(i + 1), z: 1'b0, v: 1'b0, d: 1'b0});
         put_req(i, ADD, 4'(i), 4'd1);
      end
      for (int k = 0; k < 5; k++) begin
         wait_any_grant(g);
         check("rr_order", 32'(g), 32'(rr_order[k]));
         @(posedge clk);
         #1;
         if (k == 0) begin
            sb[0].push_back('{y: 4'h6, z: 1'b0, v: 1'b0, d: 1'b0});
            put_req(0, XOR, 4'h5, 4'h3);
         end else if (g >= 0) begin
            req_valid[g] = 1'b0;
         end
      end
      req_valid = '0;
      wait_drain();

      // Back-pressure on requester 2 blocks the ALU; rr_ptr then moves to 3.
      reset_pulse();
      resp_ready = 4'b1011;
      sb[2].push_back('{y: 4'hA, z: 1'b0, v: 1'b0, d: 1'b0});
      set_req(2, OR, 4'h8, 4'h2);
      wait_any_grant(g);
      check("bp_first_grant", 32'(g), 32'd2);
      @(posedge clk);
      #1;
      req_valid[2] = 1'b0;
      sb[0].push_back('{y: 4'h2, z: 1'b0, v: 1'b0, d: 1'b0});
      put_req(0, ADD, 4'h1, 4'h1);
      sb[1].push_back('{y: 4'h4, z: 1'b0, v: 1'b0, d: 1'b0});
      put_req(1, AND, 4'hC, 4'h6);
      sb[3].push_back('{y: 4'hA, z: 1'b0, v: 1'b0, d: 1'b0});
      put_req(3, NOT, 4'h5, 4'h0);
      for (int n = 0; n < 10 && !resp_valid[2]; n++) @(negedge clk);
      check("bp_resp_seen", 32'(resp_valid), 32'b0100);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         check("bp_resp_held", 32'(resp_valid), 32'b0100);
         check("bp_resp_y_stable", 32'(resp_y), 32'hA);
         check("bp_no_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1 resp_ready = '1;
      for (int k = 0; k < 3; k++) begin
         wait_any_grant(g);
         check("bp_order", 32'(g), 32'(bp_order[k]));
         @(posedge clk);
         #1;
         if (g >= 0) req_valid[g] = 1'b0;
      end
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Round-robin controller that shares one registered 4-bit ALU among NREQ requesters. Each requester issues mode/operands with a valid/ready handshake. The controller drives the ALU, holds its inputs stable for the ALU latency, then captures Y and the flags and returns them through a per-requester response handshake. It sits between the ALU and the decode/test logic in the datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, operand/result width; must match the ALU
ALU_LAT, 2, cycles ALU inputs are held before capture; 2 because ALU flags derive from the prior-cycle result

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_mode  in  NREQ*3  per-requester op code, slice i = [3i+2:3i]
req_a  in  NREQ*WIDTH  operand A per requester
req_b  in  NREQ*WIDTH  operand B per requester
resp_valid  out  NREQ  per-requester response valid; one-hot or zero
resp_ready  in  NREQ  per-requester response accept
resp_y  out  WIDTH  captured result, shared bus
resp_zero  out  1  captured Zero
resp_ovf  out  1  captured Overflow
resp_d  out  1  captured compare output
alu_mode  out  3  ALU mode
alu_a  out  WIDTH  ALU operand A
alu_b  out  WIDTH  ALU operand B
alu_y  in  WIDTH  ALU result
alu_zero  in  1  ALU Zero
alu_ovf  in  1  ALU Overflow
alu_d  in  1  ALU compare output
busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: clk is the only clock. rst is asynchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_y/flags=0, alu_mode=3'b000, alu_a=0, alu_b=0, wait_cnt=0.
- FSM IDLE -> ISSUE:
  - If any req_valid is set, pick the first index at or after rr_ptr, wrapping modulo NREQ.
  - Assert req_ready[g] combinationally in IDLE only. The handshake completes in that same cycle.
  - Latch mode/a/b into alu_* registers and store g.
- FSM ISSUE/WAIT:
  - alu_* stay constant.
  - wait_cnt counts 1..ALU_LAT. Transition to CAPTURE when wait_cnt==ALU_LAT.
- FSM CAPTURE: register alu_y/zero/ovf/d into resp_*, set resp_valid[g], go to RESP.
- FSM RESP:
  - Hold resp_valid[g] and resp_* until resp_ready[g]=1.
  - Then clear resp_valid and set rr_ptr=(g+1) mod NREQ.
  - Go to IDLE. No new grant is made in that same cycle.
- Latency: accept at cycle 0 gives resp_valid at cycle ALU_LAT+2. Minimum throughput is one op per ALU_LAT+3 cycles.
- Only one operation is in flight. req_valid changes of other requesters while busy are ignored until IDLE.
- Requester rules:
  - A requester must keep req_valid and its data stable until ready.
  - Dropping req_valid before grant is legal; the request is simply not seen.
- rr_ptr advances only on response completion, so a requester with a stalled response blocks the ALU. This is intentional and stated for verification.
- Invalid g (NREQ not a power of 2): wrap uses compare-and-subtract, not bit truncation.
- Reset mid-operation: everything returns to reset values immediately. A pending response is lost; requesters must re-issue.
- Outputs req_ready/resp_valid never have more than one bit set (assert in sim).

Optional Feature:
ALU_SHARE_STATS_EN. When defined, adds output grant_cnt (NREQ*8 bits).
- Per-requester saturating 8-bit counters increment at each accepted request.
- Counters reset to 0 on rst and stop at 255.
When undefined, the port and the counters are absent and the rest of the behaviour is identical.

Decomposition:
Shared package alu_share_pkg holds:
- the state enum (IDLE, ISSUE, WAIT, CAPTURE, RESP);
- the ALU mode constants (ADD=0, SUB=1, NOT=2, AND=3, OR=4, XOR=5, LT=6, EQ=7).

One sub-module, rr_pick, handles the combinational round-robin selection: inputs req_valid and rr_ptr; outputs gnt_onehot, gnt_idx and any_valid.

Test Plan:
- Reset mid-WAIT: assert rst in cycle 2 of WAIT -> busy=0 and resp_valid=0 in the same cycle; alu_a/alu_b=0.
- Single request: req 1 ADD a=3, b=4 -> req_ready[1] at cycle 0; resp_valid[1] at cycle 4 with resp_y=7, zero=0, ovf=0.
- Overflow: req 0 ADD a=4'h7, b=4'h1 -> resp_y=4'h8, resp_ovf=1. Zero case: SUB a=5, b=5 -> resp_y=0, resp_zero=1.
- Round robin: all 4 req_valid held, resp_ready=1 -> grant order 0,1,2,3,0. Each resp_valid is one-hot, matching the granted index.
- Back-pressure: resp_ready[2]=0 for 10 cycles -> resp_y stable, no other req_ready asserted. After release, the next grant goes to index 3.
- Compare: req LT a=4'hE, b=4'h2 -> resp_d=1. EQ a=9, b=9 -> resp_d=1, resp_y=0.
